alu_multicycle: RTL and testbench

Parametrised multi-cycle ALU that replaces the single-cycle 32-bit combinational ALU in the execute stage. Single-cycle operations complete in one clock. MUL and DIV run iteratively for WIDTH cycles. Flags are held in a persistent register, so BRFL tests the flags produced by an earlier instruction. The control unit drives it with a start/busy/done handshake and stalls the pipeline while `busy` is high.

---
 rtl/alu_multicycle.sv | 258 +++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Execute-stage ALU with a start/busy/done handshake.
//   - Single-cycle ops finish on the edge after they are accepted.
//   - MUL and DIV iterate for WIDTH cycles on operand magnitudes.
//   - The sign is applied when the operation completes.
//   - The flag register persists across ops, so BRFL sees earlier results.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low; clears all state
//   start        launch request, sampled only while idle
//   op           5-bit opcode
//   data1/data2  signed operands, captured on the accepting edge
//   busy         high from the accepting edge through the done cycle
//   done         one-cycle completion pulse
//   result       registered result
//   zero         registered zero indication
//   flags        {error, equal, below, above, overflow}
//   branch_taken registered BRFL outcome
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4:0]              op,
  input  logic signed [WIDTH-1:0] data1,
  input  logic signed [WIDTH-1:0] data2,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic                    zero,
  output logic [4:0]              flags,
  output logic                    branch_taken
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_LW_1 = 5'd0,  OP_LW_2 = 5'd1,  OP_LW_3 = 5'd2,  OP_SW_1 = 5'd3;
  localparam logic [4:0] OP_SW_2 = 5'd4,  OP_MOV  = 5'd5,  OP_ADD  = 5'd6,  OP_SUB  = 5'd7;
  localparam logic [4:0] OP_MUL  = 5'd8,  OP_DIV  = 5'd9,  OP_AND  = 5'd10, OP_OR   = 5'd11;
  localparam logic [4:0] OP_SHL  = 5'd12, OP_SHR  = 5'd13, OP_CMP  = 5'd14, OP_NOT  = 5'd15;
  localparam logic [4:0] OP_JR   = 5'd16, OP_JPC  = 5'd17, OP_BRFL = 5'd18, OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20, OP_NOP  = 5'd21;

  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIVD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;     // product high half or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // multiplier/product low half or dividend/quotient
  logic             neg_q, neg_d;   // sign to apply at completion
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, bt_q, bt_d;
  logic [4:0]       flags_q, flags_d;

  // Operand views and single-cycle arithmetic
  logic [WIDTH-1:0] a_u, b_u, mag_a, mag_b, add_res, sub_res;
  logic             add_ovf, sub_ovf;

  assign a_u     = data1;
  assign b_u     = data2;
  assign mag_a   = data1[WIDTH-1] ? -a_u : a_u;   // MIN maps to 2^(WIDTH-1) unsigned
  assign mag_b   = data2[WIDTH-1] ? -b_u : b_u;
  assign add_res = a_u + b_u;
  assign sub_res = a_u - b_u;
  assign add_ovf = (a_u[WIDTH-1] == b_u[WIDTH-1]) && (add_res[WIDTH-1] != a_u[WIDTH-1]);
  assign sub_ovf = (a_u[WIDTH-1] != b_u[WIDTH-1]) && (sub_res[WIDTH-1] != a_u[WIDTH-1]);

  // One shift-add multiply step: conditionally add, then shift {hi,lo} right
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
  logic [2*WIDTH-1:0] mul_mag, mul_full;
  logic               mul_ovf;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign mul_mag   = {mul_hi_nx, mul_lo_nx};
  assign mul_full  = neg_q ? -mul_mag : mul_mag;
  // Overflow when the full product is not the sign extension of its low half
  assign mul_ovf   = mul_full[2*WIDTH-1:WIDTH] != {WIDTH{mul_full[WIDTH-1]}};

  // One restoring divide step: shift in next dividend bit, try subtract
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge, div_ovf;
  logic [WIDTH-1:0] div_rem_nx, div_quo_nx, div_res;

  assign div_shift  = {hi_q, lo_q[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, opa_q};
  assign div_ge     = div_shift[WIDTH] | ~div_diff[WIDTH];
  assign div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_nx = {lo_q[WIDTH-2:0], div_ge};
  assign div_res    = neg_q ? -div_quo_nx : div_quo_nx;
  // A positive quotient of magnitude 2^(WIDTH-1) only arises from MIN / -1
  assign div_ovf    = div_quo_nx[WIDTH-1] & ~neg_q;

  // Results of every op that completes on the edge after acceptance
  logic [WIDTH-1:0] sc_result;
  logic [4:0]       sc_flags;
  logic             sc_zero, sc_bt, sc_zero_op;

  always_comb begin
    sc_result  = '0;
    sc_flags   = flags_q;
    sc_bt      = 1'b0;
    sc_zero_op = 1'b0;
    case (op)
      OP_LW_1, OP_JPC: sc_result = add_res;
      OP_SW_1:         sc_result = a_u + WIDTH'(8);
      OP_LW_2, OP_LW_3, OP_SW_2, OP_JR, OP_CALL, OP_RET: sc_result = a_u;
      OP_NOP, OP_MUL:  sc_result = '0;  // MUL always takes the iterative path
      OP_MOV:          sc_result = WIDTH'({a_u[4:0], b_u[4:0]});
      OP_ADD: begin
        sc_result  = add_res;
        sc_flags   = {add_ovf, 3'b000, add_ovf};
        sc_zero_op = 1'b1;
      end
      OP_SUB: begin
        sc_result  = sub_res;
        sc_flags   = {sub_ovf, 3'b000, sub_ovf};
        sc_zero_op = 1'b1;
      end
      OP_AND: begin
        sc_result  = a_u & b_u;
        sc_zero_op = 1'b1;
      end
      OP_OR: begin
        sc_result  = a_u | b_u;
        sc_zero_op = 1'b1;
      end
      OP_NOT:          sc_result = ~a_u;
      OP_SHL:          sc_result = a_u << b_u[SHW-1:0];
      OP_SHR:          sc_result = a_u >> b_u[SHW-1:0];
      OP_CMP:          sc_flags  = {1'b0, data1 == data2, data1 < data2, data1 > data2, 1'b0};
      OP_BRFL: begin
        sc_bt     = (flags_q == b_u[4:0]);
        sc_result = sc_bt ? a_u : '0;
      end
      OP_DIV: begin    // only reached for a zero divisor
        sc_flags   = 5'b10000;
        sc_zero_op = 1'b1;
      end
      default:         sc_flags  = 5'b10000;
    endcase
    sc_zero = sc_zero_op && (sc_result == '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    flags_d  = flags_q;
    bt_d     = bt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          hi_d   = '0;
          neg_d  = data1[WIDTH-1] ^ data2[WIDTH-1];
          if (op == OP_MUL) begin
            state_d = MULT;
            opa_d   = mag_a;
            lo_d    = mag_b;
          end else if (op == OP_DIV && b_u != '0) begin
            state_d = DIVD;
            opa_d   = mag_b;
            lo_d    = mag_a;
          end else begin
            done_d   = 1'b1;
            result_d = sc_result;
            zero_d   = sc_zero;
            flags_d  = sc_flags;
            bt_d     = sc_bt;
          end
        end
      end
      MULT: begin
        busy_d = 1'b1;
        hi_d   = mul_hi_nx;
        lo_d   = mul_lo_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = mul_full[WIDTH-1:0];
          zero_d   = (mul_full[WIDTH-1:0] == '0);
          flags_d  = {mul_ovf, 3'b000, mul_ovf};
          bt_d     = 1'b0;
        end
      end
      DIVD: begin
        busy_d = 1'b1;
        hi_d   = div_rem_nx;
        lo_d   = div_quo_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = div_res;
          zero_d   = (div_res == '0);
          flags_d  = {div_ovf, 3'b000, div_ovf};
          bt_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      flags_q  <= '0;
      bt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      flags_q  <= flags_d;
      bt_q     <= bt_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign flags        = flags_q;
  assign branch_taken = bt_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle
//   Scoreboard bench: directed ops push their hand-computed response into a
//   per-DUT queue; monitors pop and compare whenever done is seen. A 32-bit
//   and a 16-bit instance share clock and reset.
module tb_alu_multicycle;

  localparam logic [4:0] LW_1 = 5'd0, LW_2 = 5'd1, SW_1 = 5'd3, MOV = 5'd5, ADD = 5'd6;
  localparam logic [4:0] SUB = 5'd7, MUL = 5'd8, DIV = 5'd9, AND_ = 5'd10, OR_ = 5'd11;
  localparam logic [4:0] SHL = 5'd12, SHR = 5'd13, CMP = 5'd14, NOT_ = 5'd15, BRFL = 5'd18;
  localparam logic [4:0] NOP = 5'd21, BAD = 5'd25;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               start32, busy32, done32, zero32, bt32;
  logic [4:0]         op32, flags32;
  logic signed [31:0] d1_32, d2_32;
  logic [31:0]        result32;

  logic               start16, busy16, done16, zero16, bt16;
  logic [4:0]         op16, flags16;
  logic signed [15:0] d1_16, d2_16;
  logic [15:0]        result16;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .data1(d1_32), .data2(d2_32),
    .busy(busy32), .done(done32), .result(result32), .zero(zero32), .flags(flags32),
    .branch_taken(bt32)
  );

  alu_multicycle #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .data1(d1_16), .data2(d2_16),
    .busy(busy16), .done(done16), .result(result16), .zero(zero16), .flags(flags16),
    .branch_taken(bt16)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic [4:0]  fl;
    logic        bt;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb32[$];
  exp_t sb16[$];
  exp_t e32, e16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string name, input logic [31:0] res, input logic z,
                              input logic [4:0] fl, input logic bt, input int lat);
    exp_t e;
    e.name = name; e.res = res; e.z = z; e.fl = fl; e.bt = bt; e.lat = lat; e.issue = cyc;
    return e;
  endfunction

  // Monitors: one pop per done pulse
  always @(negedge clk) begin
    if (reset && done32) begin
      if (sb32.size() == 0) begin
        chk("done32_unexpected", 32'(done32), 32'd0);
      end else begin
        e32 = sb32.pop_front();
        chk({e32.name, "_result"}, result32, e32.res);
        chk({e32.name, "_zero"}, 32'(zero32), 32'(e32.z));
        chk({e32.name, "_flags"}, 32'(flags32), 32'(e32.fl));
        chk({e32.name, "_branch"}, 32'(bt32), 32'(e32.bt));
        chk({e32.name, "_latency"}, 32'(cyc - e32.issue), 32'(e32.lat));
        chk({e32.name, "_busy"}, 32'(busy32), 32'd1);
        $display("txn w32 %s result=0x%08h zero=%0b flags=%05b branch=%0b latency=%0d",
                 e32.name, result32, zero32, flags32, bt32, cyc - e32.issue);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && done16) begin
      if (sb16.size() == 0) begin
        chk("done16_unexpected", 32'(done16), 32'd0);
      end else begin
        e16 = sb16.pop_front();
        chk({e16.name, "_result"}, {16'd0, result16}, e16.res);
        chk({e16.name, "_zero"}, 32'(zero16), 32'(e16.z));
        chk({e16.name, "_flags"}, 32'(flags16), 32'(e16.fl));
        chk({e16.name, "_latency"}, 32'(cyc - e16.issue), 32'(e16.lat));
        $display("txn w16 %s result=0x%04h zero=%0b flags=%05b branch=%0b latency=%0d",
                 e16.name, result16, zero16, flags16, bt16, cyc - e16.issue);
      end
    end
  end

  // Wait (bounded) until the scoreboard of one DUT has drained
  task automatic drain(input int w);
    int pending;
    for (int i = 0; i < 100; i++) begin
      pending = (w == 32) ? sb32.size() : sb16.size();
      if (pending == 0) break;
      @(negedge clk); #1;
    end
    pending = (w == 32) ? sb32.size() : sb16.size();
    chk($sformatf("drain_w%0d_pending", w), 32'(pending), 32'd0);
    if (w == 32) sb32.delete(); else sb16.delete();
  endtask

  task automatic issue(input int w, input string name, input logic [4:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                       input logic z, input logic [4:0] fl, input logic bt, input int lat);
    @(posedge clk); #1;
    if (w == 32) begin
      op32 = o; d1_32 = a; d2_32 = b; start32 = 1'b1;
      sb32.push_back(mk(name, res, z, fl, bt, lat));
    end else begin
      op16 = o; d1_16 = a[15:0]; d2_16 = b[15:0]; start16 = 1'b1;
      sb16.push_back(mk(name, res, z, fl, bt, lat));
    end
    @(posedge clk); #1;
    start32 = 1'b0;
    start16 = 1'b0;
    drain(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start32 = 1'b0; op32 = '0; d1_32 = '0; d2_32 = '0;
    start16 = 1'b0; op16 = '0; d1_16 = '0; d2_16 = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy32), 32'd0);
    chk("reset_done", 32'(done32), 32'd0);
    chk("reset_result", result32, 32'd0);
    chk("reset_zero", 32'(zero32), 32'd0);
    chk("reset_flags", 32'(flags32), 32'd0);
    chk("reset_branch", 32'(bt32), 32'd0);
    reset = 1'b1;

    //    w   name        op    data1          data2          result         z     flags     bt  lat
    issue(32, "add_ovf",  ADD,  32'h7FFFFFFF,  32'h1,         32'h80000000,  1'b0, 5'b10001, 1'b0, 1);
    issue(32, "sub_ovf",  SUB,  32'h80000000,  32'h1,         32'h7FFFFFFF,  1'b0, 5'b10001, 1'b0, 1);
    issue(32, "mul_neg",  MUL,  32'hFFFFFFFD,  32'd7,         32'hFFFFFFEB,  1'b0, 5'b00000, 1'b0, 33);
    issue(32, "mul_ovf",  MUL,  32'h00010000,  32'h00010000,  32'h0,         1'b1, 5'b10001, 1'b0, 33);
    issue(32, "div_neg",  DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0, 5'b00000, 1'b0, 33);
    issue(32, "div_zero", DIV,  32'd5,         32'd0,         32'h0,         1'b1, 5'b10000, 1'b0, 1);
    issue(32, "div_min",  DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 5'b10001, 1'b0, 33);
    issue(32, "cmp_lt",   CMP,  32'hFFFFFFFF,  32'd1,         32'h0,         1'b0, 5'b00100, 1'b0, 1);
    issue(32, "brfl_tk",  BRFL, 32'h40,        32'h04,        32'h40,        1'b0, 5'b00100, 1'b1, 1);
    issue(32, "and",      AND_, 32'hF0F0,      32'h0FF0,      32'h00F0,      1'b0, 5'b00100, 1'b0, 1);
    issue(32, "brfl_nt",  BRFL, 32'h40,        32'h08,        32'h0,         1'b0, 5'b00100, 1'b0, 1);
    issue(32, "or_zero",  OR_,  32'h0,         32'h0,         32'h0,         1'b1, 5'b00100, 1'b0, 1);
    issue(32, "shl",      SHL,  32'h1,         32'h24,        32'h10,        1'b0, 5'b00100, 1'b0, 1);
    issue(32, "shr",      SHR,  32'h80000000,  32'd31,        32'h1,         1'b0, 5'b00100, 1'b0, 1);
    issue(32, "mov",      MOV,  32'h23,        32'h3F,        32'h7F,        1'b0, 5'b00100, 1'b0, 1);
    issue(32, "sw_1",     SW_1, 32'h100,       32'h5,         32'h108,       1'b0, 5'b00100, 1'b0, 1);
    issue(32, "lw_1",     LW_1, 32'h3,         32'h4,         32'h7,         1'b0, 5'b00100, 1'b0, 1);
    issue(32, "not",      NOT_, 32'h0,         32'h0,         32'hFFFFFFFF,  1'b0, 5'b00100, 1'b0, 1);
    issue(32, "invalid",  BAD,  32'h12,        32'h34,        32'h0,         1'b0, 5'b10000, 1'b0, 1);
    issue(32, "brfl_err", BRFL, 32'h77,        32'h10,        32'h77,        1'b0, 5'b10000, 1'b1, 1);
    issue(32, "nop",      NOP,  32'h9,         32'h9,         32'h0,         1'b0, 5'b10000, 1'b0, 1);

    // start pulsed during MULT must be ignored
    @(posedge clk); #1;
    op32 = MUL; d1_32 = 32'd6; d2_32 = 32'd7; start32 = 1'b1;
    sb32.push_back(mk("mul_busy", 32'd42, 1'b0, 5'b00000, 1'b0, 33));
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op32 = ADD; d1_32 = 32'd1; d2_32 = 32'd1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    chk("busy_during_mult", 32'(busy32), 32'd1);
    drain(32);
    repeat (3) @(posedge clk);

    // start held across done: second op accepted in the done cycle
    @(posedge clk); #1;
    op32 = ADD; d1_32 = 32'd1; d2_32 = 32'd2; start32 = 1'b1;
    sb32.push_back(mk("b2b_add", 32'd3, 1'b0, 5'b00000, 1'b0, 1));
    @(posedge clk); #1;
    op32 = OR_; d1_32 = 32'd3; d2_32 = 32'd4;
    sb32.push_back(mk("b2b_or", 32'd7, 1'b0, 5'b00000, 1'b0, 1));
    @(posedge clk); #1;
    start32 = 1'b0;
    drain(32);

    // leave non-zero state behind, then abort a DIV with reset
    issue(32, "cmp_eq",   CMP,  32'd5,         32'd5,         32'h0,         1'b0, 5'b01000, 1'b0, 1);
    issue(32, "lw_2",     LW_2, 32'h55,        32'h0,         32'h55,        1'b0, 5'b01000, 1'b0, 1);
    @(posedge clk); #1;
    op32 = DIV; d1_32 = 32'd100; d2_32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy32), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy32), 32'd0);
    chk("abort_done", 32'(done32), 32'd0);
    chk("abort_result", result32, 32'd0);
    chk("abort_flags", 32'(flags32), 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    chk("abort_no_done_busy", 32'(busy32), 32'd0);

    // 16-bit instance
    issue(16, "mul16",    MUL,  32'hFFFD,      32'd7,         32'hFFEB,      1'b0, 5'b00000, 1'b0, 17);
    issue(16, "shr16",    SHR,  32'h8000,      32'd15,        32'h0001,      1'b0, 5'b00000, 1'b0, 1);

    repeat (3) @(posedge clk);
    chk("sb32_empty", 32'(sb32.size()), 32'd0);
    chk("sb16_empty", 32'(sb16.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
